// File: rtl/pio_keyboard_in_irq.sv
// Avalon-MM input PIO for front-panel switches and keys.
// Each input bit passes through a synchroniser, a debounce filter, an edge
// detector and a sticky edge-capture register. A per-bit mask turns captured
// edges into a level interrupt for the CPU.
module pio_keyboard_in_irq #(
  parameter int WIDTH           = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Zero-extend a WIDTH-bit register to the 32-bit bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Selects which transitions of the debounced value count as an event.
  function automatic logic [WIDTH-1:0] edge_select(input logic [WIDTH-1:0] rise,
                                                   input logic [WIDTH-1:0] fall);
    logic [WIDTH-1:0] r;
    case (EDGE_TYPE)
      0:       r = rise;
      1:       r = fall;
      default: r = rise | fall;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [CNT_W-1:0] db_cnt [WIDTH];
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH carry no meaning.
  assign unused_wdata = ^writedata;

  // ---- stage: metastability synchroniser ----
  // Shift raw inputs through a SYNC_STAGES-deep flop chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_p[s] <= '0;
      end
    end else begin
      sync_p[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_p[s] <= sync_p[s-1];
      end
    end
  end

  assign sync_out = sync_p[SYNC_STAGES-1];

  // ---- stage: debounce filter ----
  // Per bit: the stable value only follows the synchronised input after it
  // has disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement in
  // between restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= sync_out[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // ---- stage: edge detection ----
  // Remember last cycle's stable value to expose transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_prev <= '0;
    end else begin
      stable_prev <= stable;
    end
  end

  assign rise     = stable & ~stable_prev;
  assign fall     = ~stable & stable_prev;
  assign edge_hit = edge_select(rise, fall);

  // Bus write decode; writes to DATA and the reserved slot are dropped.
  assign wr_en    = chipselect & ~write_n;
  assign wr_mask  = wr_en && (address == ADDR_MASK);
  assign wr_edge  = wr_en && (address == ADDR_EDGE);
  assign clr_bits = wr_edge ? writedata[WIDTH-1:0] : '0;

  // ---- stage: capture and mask registers ----
  // Interrupt mask register, written directly from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_mask) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky capture with write-1-to-clear; a new edge beats a clear on the
  // same bit so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~clr_bits) | edge_hit;
    end
  end

  // Level interrupt from registered state only, no bus-input path.
  assign irq = |(edgecapture & irqmask);

  // ---- stage: registered read port ----
  // Read mux is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA: readdata <= zext(stable);
        ADDR_MASK: readdata <= zext(irqmask);
        ADDR_EDGE: readdata <= zext(edgecapture);
        default:   readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_keyboard_in_irq.sv
// Testbench for pio_keyboard_in_irq with WIDTH=6, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, EDGE_TYPE=2 (any edge).
module tb_pio_keyboard_in_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [5:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [14];

  pio_keyboard_in_irq #(
    .WIDTH(6),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [1:0] a, input logic cs, input logic wn,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic ir);
    vec_t v;
    v.addr = a; v.cs = cs; v.wn = wn; v.wdata = wd; v.exp_rd = rd; v.exp_irq = ir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    step();
    bus_idle();
  endtask

  initial begin
    reset_n = 1'b0;
    in_port = 6'h00;
    address = 2'd0;
    bus_idle();

    // Reset state
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // Register map table
    tbl[0]  = mk(2'd0, 1'b0, 1'b1, 32'h0,        32'h00, 1'b0);
    tbl[1]  = mk(2'd1, 1'b0, 1'b1, 32'h0,        32'h00, 1'b0);
    tbl[2]  = mk(2'd3, 1'b0, 1'b1, 32'h0,        32'h00, 1'b0);
    tbl[3]  = mk(2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00, 1'b0);
    tbl[4]  = mk(2'd1, 1'b0, 1'b1, 32'h0,        32'h3F, 1'b0);
    tbl[5]  = mk(2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00, 1'b0);
    tbl[6]  = mk(2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00, 1'b0);
    tbl[7]  = mk(2'd2, 1'b0, 1'b1, 32'h0,        32'h00, 1'b0);
    tbl[8]  = mk(2'd1, 1'b0, 1'b0, 32'h0,        32'h3F, 1'b0);
    tbl[9]  = mk(2'd1, 1'b0, 1'b1, 32'h0,        32'h3F, 1'b0);
    tbl[10] = mk(2'd1, 1'b1, 1'b0, 32'h04,       32'h3F, 1'b0);
    tbl[11] = mk(2'd1, 1'b0, 1'b1, 32'h0,        32'h04, 1'b0);
    tbl[12] = mk(2'd3, 1'b1, 1'b0, 32'h3F,       32'h00, 1'b0);
    tbl[13] = mk(2'd0, 1'b0, 1'b1, 32'h0,        32'h00, 1'b0);

    for (int i = 0; i < 14; i++) begin
      address    = tbl[i].addr;
      chipselect = tbl[i].cs;
      write_n    = tbl[i].wn;
      writedata  = tbl[i].wdata;
      step();
      check($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end
    bus_idle();
    address = 2'd0;

    // Bit 2 glitch of 3 cycles: sync_out differs for only 3 cycles, one short
    in_port = 6'h04;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("glitch_hi%0d", k), readdata, 32'h0);
    end
    in_port = 6'h00;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("glitch_lo%0d", k), readdata, 32'h0);
    end
    address = 2'd3;
    step();
    check("glitch_edgecap", readdata, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Clean step 00->05. stable updates on the 6th edge after sampling, so
    // the registered DATA read shows it from the 7th edge on.
    address = 2'd0;
    in_port = 6'h05;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("step_rd_e%0d", k), readdata, 32'h0);
      check($sformatf("step_irq_e%0d", k), {31'b0, irq}, 32'h0);
    end
    step();
    check("step_rd_e7", readdata, 32'h05);
    check("step_irq_e7", {31'b0, irq}, 32'h1);
    address = 2'd3;
    step();
    check("step_edgecap", readdata, 32'h05);

    bus_write(2'd3, 32'h3F);
    check("clr_all_rd_old", readdata, 32'h05);
    check("clr_all_irq", {31'b0, irq}, 32'h0);
    step();
    check("clr_all_edgecap", readdata, 32'h0);

    // Falling edge on bit 2 with mask 0x04
    in_port = 6'h01;
    repeat (6) step();
    check("fall2_irq_e6", {31'b0, irq}, 32'h0);
    step();
    check("fall2_irq_e7", {31'b0, irq}, 32'h1);
    step();
    check("fall2_edgecap", readdata, 32'h04);
    bus_write(2'd3, 32'h04);
    check("w1c2_irq", {31'b0, irq}, 32'h0);
    step();
    check("w1c2_edgecap", readdata, 32'h0);

    // Second edge on bit 2, then mask off and back on
    in_port = 6'h05;
    repeat (6) step();
    check("rise2_irq_e6", {31'b0, irq}, 32'h0);
    step();
    check("rise2_irq_e7", {31'b0, irq}, 32'h1);
    bus_write(2'd1, 32'h00);
    check("mask_off_irq", {31'b0, irq}, 32'h0);
    bus_write(2'd1, 32'h04);
    check("mask_on_irq", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h3F);
    check("clr2_irq", {31'b0, irq}, 32'h0);

    // W1C of bit 0 in the very cycle a new bit-0 edge is captured
    address = 2'd3;
    in_port = 6'h04;
    repeat (6) step();
    bus_write(2'd3, 32'h01);
    check("race_irq", {31'b0, irq}, 32'h0);
    step();
    check("race_edgecap", readdata, 32'h01);
    bus_write(2'd3, 32'h01);
    step();
    check("race_cleared", readdata, 32'h0);

    // Reset mid-count with the input held high through reset
    address = 2'd1;
    step();
    check("pre_rst_mask", readdata, 32'h04);
    in_port = 6'h00;
    repeat (3) step();
    reset_n = 1'b0;
    in_port = 6'h04;
    #1;
    check("async_rst_rd", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    address = 2'd3;
    repeat (10) step();
    check("post_rst_edgecap", readdata, 32'h04);
    address = 2'd0;
    step();
    check("post_rst_data", readdata, 32'h04);
    address = 2'd1;
    step();
    check("post_rst_mask", readdata, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
